// File: rtl/start_fifo_ctrl_pkg.sv
// start_fifo_ctrl_pkg: shared types and elaboration helpers for the start FIFO.
// No ports. It provides:
//   MAX_DEPTH         - largest supported FIFO depth
//   occ_t             - occupancy type wide enough for MAX_DEPTH entries
//   calc_addr_width() - storage address width for a depth (clog2, minimum 1)
package start_fifo_ctrl_pkg;
   localparam int MAX_DEPTH = 64;
   typedef logic [$clog2(MAX_DEPTH):0] occ_t;
   function automatic int calc_addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction
endpackage

// File: rtl/start_fifo_srl.sv
// start_fifo_srl: shift-register storage with a combinational read port.
// Ports:
//   clk  - shift clock
//   we   - shift enable; din enters entry 0 and older entries move up by one
//   addr - read address; 0 is the newest entry
//   din  - write payload
//   dout - entry at addr, combinational
// The storage has no reset. Its contents only matter where the controller points addr.
module start_fifo_srl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   localparam int N = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [N];
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[0] <= din;
         for (int i = 1; i < N; i++) mem_q[i] <= mem_q[i-1];
      end
   end
   assign dout = mem_q[addr];
endmodule

// File: rtl/start_fifo_ctrl.sv
// start_fifo_ctrl: controller for a shift-register start/handshake FIFO.
// Ports:
//   ap_clk, ap_rst_n            - clock and asynchronous active-low reset
//   if_write_ce, if_write       - producer write enable and request
//   if_din                      - write payload
//   if_full_n, if_almost_full   - registered producer flags
//   if_read_ce, if_read         - consumer read enable and request
//   if_dout                     - oldest entry (show-ahead)
//   if_empty_n                  - registered consumer flag
//   count                       - occupancy, 0..DEPTH
//   err_overflow, err_underflow - sticky protocol error flags
module start_fifo_ctrl
   import start_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = 1,
   parameter int AF_LEVEL   = DEPTH - 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   output logic                  if_almost_full,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  err_overflow,
   output logic                  err_underflow
);
   if (DEPTH < 2 || DEPTH > MAX_DEPTH || ADDR_WIDTH < calc_addr_width(DEPTH)) begin : g_bad_cfg
      $error("start_fifo_ctrl: unsupported DEPTH/ADDR_WIDTH combination");
   end
   localparam logic [ADDR_WIDTH:0] ONE     = 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr;
   logic full_n_q, empty_n_q, af_q, ovf_q, unf_q, wr_acc, rd_acc;
   always_comb begin
      wr_acc  = if_write_ce & if_write & full_n_q;
      rd_acc  = if_read_ce & if_read & empty_n_q;
      count_d = (wr_acc && !rd_acc) ? count_q + ONE :
                (rd_acc && !wr_acc) ? count_q - ONE : count_q;
      // Oldest entry sits at count-1; a simultaneous shift moves the next-oldest into that slot.
      addr    = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - ONE);
   end
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         count_q   <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
         af_q      <= (AF_LEVEL == 0);
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         full_n_q  <= (count_d != DEPTH_C);
         empty_n_q <= (count_d != '0);
         af_q      <= (count_d >= AF_C);
         ovf_q     <= ovf_q | (if_write_ce & if_write & ~full_n_q);
         unf_q     <= unf_q | (if_read_ce & if_read & ~empty_n_q);
      end
   end
   start_fifo_srl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_srl (
      .clk  (ap_clk),
      .we   (wr_acc),
      .addr (addr),
      .din  (if_din),
      .dout (if_dout)
   );
   assign if_full_n      = full_n_q;
   assign if_empty_n     = empty_n_q;
   assign if_almost_full = af_q;
   assign count          = count_q;
   assign err_overflow   = ovf_q;
   assign err_underflow  = unf_q;
endmodule

// File: tb/tb_start_fifo_ctrl.sv
// tb_start_fifo_ctrl: scoreboard bench for start_fifo_ctrl (DEPTH=4, AF_LEVEL=3).
module tb_start_fifo_ctrl;
   localparam int DW = 8;
   localparam int D  = 4;
   localparam int AW = 2;
   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic [DW-1:0] if_dout;
   logic          if_full_n, if_almost_full, if_empty_n, err_overflow, err_underflow;
   logic [AW:0]   count;
   int            checks = 0;
   int            errors = 0;
   int            mcount = 0;
   logic [DW-1:0] exp_q [$];

   start_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .AF_LEVEL(3)) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .if_write_ce    (if_write_ce),
      .if_write       (if_write),
      .if_din         (if_din),
      .if_full_n      (if_full_n),
      .if_almost_full (if_almost_full),
      .if_read_ce     (if_read_ce),
      .if_read        (if_read),
      .if_dout        (if_dout),
      .if_empty_n     (if_empty_n),
      .count          (count),
      .err_overflow   (err_overflow),
      .err_underflow  (err_underflow)
   );

   always #5 ap_clk = ~ap_clk;

   // Monitor: whenever the DUT presents data to an active read, pop the scoreboard and compare.
   always @(negedge ap_clk) begin
      if (ap_rst_n && if_read_ce && if_read && if_empty_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_data: got %h, nothing expected", if_dout);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (if_dout !== e) begin
               errors++;
               $display("FAIL rd_data: got %h, expected %h", if_dout, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the model decides acceptance and feeds the scoreboard.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic wce, input logic rce);
      bit wa, ra;
      if_write = w; if_din = d; if_read = r; if_write_ce = wce; if_read_ce = rce;
      wa = wce && w && (mcount != D);
      ra = rce && r && (mcount != 0);
      if (wa) exp_q.push_back(d);
      mcount = mcount + int'(wa) - int'(ra);
      @(posedge ap_clk);
      #1;
      if_write = 1'b0; if_read = 1'b0; if_write_ce = 1'b0; if_read_ce = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge ap_clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty_n", 32'(if_empty_n), 0);
      chk("rst_full_n", 32'(if_full_n), 1);
      chk("rst_af", 32'(if_almost_full), 0);
      chk("rst_errs", {30'd0, err_overflow, err_underflow}, 0);
      ap_rst_n = 1'b1;
      // Fill to full
      step(1, 8'h0A, 0, 1, 1);
      step(1, 8'h0B, 0, 1, 1);
      step(1, 8'h0C, 0, 1, 1);
      chk("af_after_3", 32'(if_almost_full), 1);
      chk("full_n_after_3", 32'(if_full_n), 1);
      step(1, 8'h0D, 0, 1, 1);
      chk("full_n_after_4", 32'(if_full_n), 0);
      chk("count_full", 32'(count), 4);
      // CE-gated write while full is ignored
      step(1, 8'h0E, 0, 0, 1);
      chk("ce_wr_count", 32'(count), 4);
      chk("ce_wr_ovf", 32'(err_overflow), 0);
      // Overflow write is dropped
      step(1, 8'h0F, 0, 1, 1);
      chk("ovf_count", 32'(count), 4);
      chk("ovf_flag", 32'(err_overflow), 1);
      repeat (4) step(0, 8'h00, 1, 1, 1);
      chk("drain_empty_n", 32'(if_empty_n), 0);
      chk("drain_count", 32'(count), 0);
      chk("drain_full_n", 32'(if_full_n), 1);
      chk("drain_af", 32'(if_almost_full), 0);
      chk("ovf_sticky", 32'(err_overflow), 1);
      // CE-gated read while empty, then real underflow
      step(0, 8'h00, 1, 1, 0);
      chk("ce_rd_unf", 32'(err_underflow), 0);
      step(0, 8'h00, 1, 1, 1);
      chk("unf_flag", 32'(err_underflow), 1);
      chk("unf_count", 32'(count), 0);
      // Write + read while empty: only the write lands
      step(1, 8'h05, 1, 1, 1);
      chk("wr_rd_empty_count", 32'(count), 1);
      chk("wr_rd_empty_dout", 32'(if_dout), 32'h05);
      chk("wr_rd_empty_en", 32'(if_empty_n), 1);
      // Sustained simultaneous traffic at occupancy 2
      step(1, 8'h06, 0, 1, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(8'h07 + i), 1, 1, 1);
         chk("sim_count", 32'(count), 2);
      end
      // Write + read while full: only the read lands
      step(1, 8'h20, 0, 1, 1);
      step(1, 8'h21, 0, 1, 1);
      chk("refill_count", 32'(count), 4);
      step(1, 8'h22, 1, 1, 1);
      chk("wr_rd_full_count", 32'(count), 3);
      chk("wr_rd_full_full_n", 32'(if_full_n), 1);
      repeat (3) step(0, 8'h00, 1, 1, 1);
      chk("drain2_empty_n", 32'(if_empty_n), 0);
      // Asynchronous reset mid-cycle discards contents
      step(1, 8'h30, 0, 1, 1);
      step(1, 8'h31, 0, 1, 1);
      #3;
      ap_rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_empty_n", 32'(if_empty_n), 0);
      chk("arst_full_n", 32'(if_full_n), 1);
      chk("arst_errs", {30'd0, err_overflow, err_underflow}, 0);
      exp_q.delete();
      mcount = 0;
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      step(1, 8'h33, 0, 1, 1);
      chk("post_rst_count", 32'(count), 1);
      chk("post_rst_empty_n", 32'(if_empty_n), 1);
      step(0, 8'h00, 1, 1, 1);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
